// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/mult_sign_adjust.sv
// Conditional two's-complement negate: result = neg ? -value : value.
// Used for operand magnitudes and for re-applying the product sign.
module mult_sign_adjust #(
    parameter int W = 4
) (
    input  logic         neg,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    // Negate by invert-plus-one when requested, otherwise pass through.
    always_comb begin
        result = value;
        if (neg) begin
            result = (~value) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
    end

endmodule : mult_sign_adjust

// File: rtl/seq_multiplier_nbit.sv
// Iterative shift-and-add multiplier, one partial product per clock.
// Signed mode multiplies magnitudes and negates the result when the
// operand signs differ. Latency is always WIDTH cycles after acceptance.
module seq_multiplier_nbit
    import mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    mult_state_t          state_r;
    logic                 sign_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   product_r;

    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [2*WIDTH-1:0]   partial_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [2*WIDTH-1:0]   result_s;
    logic                 last_iter_s;

    assign a_neg_s = signed_mode & a[WIDTH-1];
    assign b_neg_s = signed_mode & b[WIDTH-1];

    mult_sign_adjust #(.W(WIDTH)) u_abs_a (
        .neg    (a_neg_s),
        .value  (a),
        .result (a_mag_s)
    );

    mult_sign_adjust #(.W(WIDTH)) u_abs_b (
        .neg    (b_neg_s),
        .value  (b),
        .result (b_mag_s)
    );

    // Current partial product and the accumulator value after this step.
    always_comb begin
        partial_s  = {(2*WIDTH){1'b0}};
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            partial_s = {{WIDTH{1'b0}}, mcand_r} << count_r;
        end else begin
            partial_s = {(2*WIDTH){1'b0}};
        end
        acc_next_s = acc_r + partial_s;
    end

    assign last_iter_s = (count_r == CNT_W'(WIDTH - 1));

    // Final result with the sign re-applied; -0 cannot occur since 0 negates to 0.
    mult_sign_adjust #(.W(2*WIDTH)) u_neg_res (
        .neg    (sign_r),
        .value  (acc_next_s),
        .result (result_s)
    );

    // Control FSM and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            sign_r    <= 1'b0;
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            count_r   <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand_r  <= a_mag_s;
                        mplier_r <= b_mag_s;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        count_r  <= {CNT_W{1'b0}};
                        state_r  <= CALC;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                CALC: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + CNT_W'(1);
                    if (last_iter_s) begin
                        product_r <= result_s;
                        state_r   <= DONE;
                    end else begin
                        state_r   <= CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decoded directly from the registered state.
    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r == CALC);
    assign out_valid = (state_r == DONE);
    assign product   = product_r;

endmodule : seq_multiplier_nbit

// File: tb/tb_seq_multiplier_nbit.sv
// Directed self-checking bench for seq_multiplier_nbit at WIDTH=4.
module tb_seq_multiplier_nbit;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int n_cmp;
    int n_bad;

    seq_multiplier_nbit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run one operation with out_ready asserted once the result appears.
    // Called at posedge+1; returns at posedge+1 after the output handshake.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sm, output logic [2*W-1:0] prod,
                         output int lat, output logic busy_ok,
                         output logic post_ok);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        prod = product;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        post_ok = (out_valid === 1'b0) && (in_ready === 1'b1) && (product === prod);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (product !== 8'h00) begin n_bad++; $display("FAIL reset_product got=%h want=00", product); end
    endtask

    task automatic test_vectors();
        logic [W-1:0]   va [6];
        logic [W-1:0]   vb [6];
        logic           vs [6];
        logic [2*W-1:0] vp [6];
        logic [2*W-1:0] p;
        int             lat;
        logic           bok, pok;
        va = '{4'b0000, 4'b1111, 4'b1110, 4'b1110, 4'b1000, 4'b0111};
        vb = '{4'b0000, 4'b1111, 4'b0011, 4'b0011, 4'b1000, 4'b1000};
        vs = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b1};
        vp = '{8'b00000000, 8'b11100001, 8'b00101010,
               8'b11111010, 8'b01000000, 8'b11001000};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vs[i], p, lat, bok, pok);
            n_cmp++; if (p !== vp[i]) begin n_bad++; $display("FAIL vec%0d_product got=%b want=%b", i, p, vp[i]); end
            n_cmp++; if (lat != W) begin n_bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, W); end
            n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL vec%0d_busy_calc got=%b want=1", i, bok); end
            n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL vec%0d_post_handshake got=%b want=1", i, pok); end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        a = 4'd3; b = 4'd5; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_reach_done got=%b want=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; a = 4'(i + 7); b = 4'(i + 2); signed_mode = ~i[0];
            @(posedge clk); #1;
            n_cmp++; if (product !== 8'd15 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold%0d got=p%0d v%b r%b bz%b want=p15 v1 r0 bz0", i, product, out_valid, in_ready, busy);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got=v%b r%b want=v0 r1", out_valid, in_ready); end
        n_cmp++; if (product !== 8'd15) begin n_bad++; $display("FAIL bp_retain got=%0d want=15", product); end
        a = 4'd2; b = 4'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept got=bz%b r%b want=bz1 r0", busy, in_ready); end
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        n_cmp++; if (product !== 8'd12) begin n_bad++; $display("FAIL bp_next_product got=%0d want=12", product); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic [2*W-1:0] p;
        int             lat;
        logic           bok, pok;
        a = 4'd9; b = 4'd7; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || product !== 8'h00) begin
            n_bad++; $display("FAIL midrst_state got=v%b r%b bz%b p%h want=v0 r1 bz0 p00", out_valid, in_ready, busy, product);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_no_output got=v%b r%b want=v0 r1", out_valid, in_ready); end
        do_op(4'd3, 4'd5, 1'b0, p, lat, bok, pok);
        n_cmp++; if (p !== 8'd15) begin n_bad++; $display("FAIL midrst_product got=%0d want=15", p); end
        n_cmp++; if (lat != W) begin n_bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, W); end
    endtask

    task automatic test_back_to_back();
        int edges;
        int guard;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 4'd5; b = 4'd5; signed_mode = 1'b0;
        @(posedge clk); #1;
        edges = 0;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            n_cmp++; if (out_valid === 1'b1 && product !== 8'd25) begin n_bad++; $display("FAIL b2b_product got=%0d want=25", product); end
            @(posedge clk); #1; edges++; guard++;
        end
        n_cmp++; if (edges + 1 != W + 2) begin n_bad++; $display("FAIL b2b_period got=%0d want=%0d", edges + 1, W + 2); end
        in_valid = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [2*W-1:0] p, exp;
        logic [2*W-1:0] ua, ub;
        logic signed [2*W-1:0] sp;
        int             lat;
        logic           bok, pok;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    ua = 8'(i); ub = 8'(j);
                    if (m == 1) begin
                        sp = $signed(4'(i)) * $signed(4'(j));
                        exp = sp;
                    end else begin
                        exp = ua * ub;
                    end
                    do_op(4'(i), 4'(j), m[0], p, lat, bok, pok);
                    n_cmp++; if (p !== exp || lat != W || pok !== 1'b1) begin
                        n_bad++; $display("FAIL sweep m%0d a%0d b%0d got=%b lat%0d want=%b lat%0d", m, i, j, p, lat, exp, W);
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_multiplier_nbit
